// File: rtl/gb_dma_interconnect.sv
// Bus interconnect: splits the CPU bus into main/high buses, decodes active-low
// region selects and runs an OAM-style DMA engine that locks the CPU off the main bus.
module gb_dma_interconnect #(
  parameter logic [15:0] DMA_REG_ADDR    = 16'hFF46,
  parameter logic [15:0] DST_BASE        = 16'hFE00,
  parameter int          DMA_LEN         = 160,
  parameter int          CYCLES_PER_BYTE = 4,
  parameter int          START_DELAY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        cpu_nread,
  input  logic        cpu_nwrite,
  output logic [15:0] main_address,
  output logic [7:0]  main_wdata,
  input  logic [7:0]  main_rdata,
  output logic        main_nread,
  output logic        main_nwrite,
  output logic [4:0]  main_nsel,
  output logic [15:0] high_address,
  output logic [7:0]  high_wdata,
  input  logic [7:0]  high_rdata,
  output logic        high_nread,
  output logic        high_nwrite,
  output logic [2:0]  high_nsel,
  output logic        dma_active
);

  localparam int          PAD_CYCLES = CYCLES_PER_BYTE - 2;
  localparam logic [15:0] PAD_LAST   = 16'((PAD_CYCLES > 0) ? PAD_CYCLES - 1 : 0);
  localparam logic [15:0] DELAY_LAST = 16'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [7:0]  LAST_IDX   = 8'(DMA_LEN - 1);

  typedef enum logic [2:0] {IDLE, DELAY, RD, WR, PAD} state_e;

  state_e      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  dbuf_q, dbuf_d;
  logic [15:0] cnt_q, cnt_d;
  logic        byteDone;

  logic        isHigh, isDmaReg, dmaWrite;
  logic [7:0]  srcPage;
  logic [15:0] srcAddr, dstAddr;
  logic        mainSel, highSel;

  assign isHigh   = (cpu_address >= 16'hFF00);
  assign isDmaReg = (cpu_address == DMA_REG_ADDR);
  assign dmaWrite = isDmaReg && !cpu_nwrite;

  // Pages E0-FF alias the WRAM echo region back onto C0-DF.
  assign srcPage    = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;
  assign srcAddr    = {srcPage, 8'h00} + {8'h00, idx_q};
  assign dstAddr    = DST_BASE + {8'h00, idx_q};
  assign dma_active = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      dbuf_q  <= 8'h00;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      dbuf_q  <= dbuf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    dbuf_d   = dbuf_q;
    cnt_d    = cnt_q;
    byteDone = 1'b0;
    case (state_q)
      DELAY: begin
        if (cnt_q == DELAY_LAST) state_d = RD;
        else                     cnt_d   = cnt_q + 16'd1;
      end
      RD: begin
        dbuf_d  = main_rdata;
        state_d = WR;
      end
      WR: begin
        if (PAD_CYCLES > 0) begin
          state_d = PAD;
          cnt_d   = 16'h0000;
        end else begin
          byteDone = 1'b1;
        end
      end
      PAD: begin
        if (cnt_q == PAD_LAST) byteDone = 1'b1;
        else                   cnt_d    = cnt_q + 16'd1;
      end
      default: ;
    endcase
    if (byteDone) begin
      if (idx_q < LAST_IDX) begin
        idx_d   = idx_q + 8'd1;
        state_d = RD;
      end else begin
        state_d = IDLE;
      end
    end
    // A register write (re)starts the transfer; an in-flight WR has already been driven.
    if (dmaWrite) begin
      page_d  = cpu_wdata;
      idx_d   = 8'h00;
      cnt_d   = 16'h0000;
      state_d = (START_DELAY == 0) ? RD : DELAY;
    end
  end

  always_comb begin
    main_address = cpu_address;
    main_wdata   = cpu_wdata;
    main_nread   = isHigh | cpu_nread;
    main_nwrite  = isHigh | cpu_nwrite;
    if (dma_active) begin
      main_address = (state_q == WR) ? dstAddr : srcAddr;
      main_wdata   = dbuf_q;
      main_nread   = (state_q != RD);
      main_nwrite  = (state_q != WR);
    end
    high_address = cpu_address;
    high_wdata   = cpu_wdata;
    high_nread   = !(isHigh && !isDmaReg) | cpu_nread;
    high_nwrite  = !(isHigh && !isDmaReg) | cpu_nwrite;
  end

  assign mainSel = !(main_nread & main_nwrite);
  assign highSel = !(high_nread & high_nwrite);

  always_comb begin
    main_nsel[0] = !(mainSel && (main_address < 16'h8000));
    main_nsel[1] = !(mainSel && (main_address >= 16'h8000) && (main_address <= 16'h9FFF));
    main_nsel[2] = !(mainSel && (main_address >= 16'hA000) && (main_address <= 16'hBFFF));
    main_nsel[3] = !(mainSel && (main_address >= 16'hC000) && (main_address <= 16'hFDFF));
    main_nsel[4] = !(mainSel && (main_address >= 16'hFE00) && (main_address <= 16'hFE9F));
    high_nsel[0] = !(highSel && (high_address >= 16'hFF00) && (high_address <= 16'hFF7F));
    high_nsel[1] = !(highSel && (high_address >= 16'hFF80) && (high_address <= 16'hFFFE));
    high_nsel[2] = !(highSel && (high_address == 16'hFFFF));
  end

  always_comb begin
    cpu_rdata = main_rdata;
    if (isDmaReg)
      cpu_rdata = page_q;
    else if (isHigh)
      cpu_rdata = high_rdata;
    else if (dma_active)
      cpu_rdata = 8'hFF;
    else if (cpu_address >= 16'hFEA0)
      cpu_rdata = 8'hFF;
  end

endmodule

// File: tb/tb_gb_dma_interconnect.sv
// Directed testbench for gb_dma_interconnect: passthrough decode, DMA timing/data,
// lockout, echo mirror with restart, reset mid-transfer and a minimal parameter set.
module tb_gb_dma_interconnect;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic [15:0] cpuAddress;
  logic [7:0]  cpuWdata, cpuRdata;
  logic        cpuNread, cpuNwrite;
  logic [15:0] mainAddress, highAddress;
  logic [7:0]  mainWdata, mainRdata, highWdata, highRdata;
  logic        mainNread, mainNwrite, highNread, highNwrite, dmaActive;
  logic [4:0]  mainNsel;
  logic [2:0]  highNsel;

  logic [15:0] cpuAddressB;
  logic [7:0]  cpuWdataB, cpuRdataB;
  logic        cpuNreadB, cpuNwriteB;
  logic [15:0] mainAddressB, highAddressB;
  logic [7:0]  mainWdataB, mainRdataB, highWdataB;
  logic        mainNreadB, mainNwriteB, highNreadB, highNwriteB, dmaActiveB;
  logic [4:0]  mainNselB;
  logic [2:0]  highNselB;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] srcMem [0:65535];
  assign mainRdata  = srcMem[mainAddress];
  assign mainRdataB = (mainAddressB == 16'h1000) ? 8'h9D : 8'h00;

  gb_dma_interconnect dut (
    .clock(clock), .reset(reset),
    .cpu_address(cpuAddress), .cpu_wdata(cpuWdata), .cpu_rdata(cpuRdata),
    .cpu_nread(cpuNread), .cpu_nwrite(cpuNwrite),
    .main_address(mainAddress), .main_wdata(mainWdata), .main_rdata(mainRdata),
    .main_nread(mainNread), .main_nwrite(mainNwrite), .main_nsel(mainNsel),
    .high_address(highAddress), .high_wdata(highWdata), .high_rdata(highRdata),
    .high_nread(highNread), .high_nwrite(highNwrite), .high_nsel(highNsel),
    .dma_active(dmaActive)
  );

  gb_dma_interconnect #(.DMA_LEN(1), .CYCLES_PER_BYTE(2), .START_DELAY(0)) dutB (
    .clock(clock), .reset(reset),
    .cpu_address(cpuAddressB), .cpu_wdata(cpuWdataB), .cpu_rdata(cpuRdataB),
    .cpu_nread(cpuNreadB), .cpu_nwrite(cpuNwriteB),
    .main_address(mainAddressB), .main_wdata(mainWdataB), .main_rdata(mainRdataB),
    .main_nread(mainNreadB), .main_nwrite(mainNwriteB), .main_nsel(mainNselB),
    .high_address(highAddressB), .high_wdata(highWdataB), .high_rdata(8'h00),
    .high_nread(highNreadB), .high_nwrite(highNwriteB), .high_nsel(highNselB),
    .dma_active(dmaActiveB)
  );

  // cyc counts edges; an event seen after edge n is logged as cycle n+1.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [15:0] rdAddrQ[$];
  int          rdCycQ[$];
  logic [15:0] wrAddrQ[$];
  logic [7:0]  wrDataQ[$];
  int          wrCycQ[$];
  int          activeCnt = 0;

  always @(negedge clock) begin
    if (!mainNread) begin
      rdAddrQ.push_back(mainAddress);
      rdCycQ.push_back(cyc + 1);
    end
    if (!mainNwrite) begin
      wrAddrQ.push_back(mainAddress);
      wrDataQ.push_back(mainWdata);
      wrCycQ.push_back(cyc + 1);
    end
    if (dmaActive) activeCnt <= activeCnt + 1;
  end

  task automatic cpuIdle();
    cpuAddress = 16'h0000; cpuWdata = 8'h00; cpuNread = 1'b1; cpuNwrite = 1'b1;
  endtask

  task automatic cpuWrite(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    cpuAddress = a; cpuWdata = d; cpuNread = 1'b1; cpuNwrite = 1'b0;
    @(posedge clock);
    #1;
    cpuIdle();
  endtask

  task automatic waitDmaDone(input string name);
    int n;
    n = 0;
    while (dmaActive && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    compared++;
    if (dmaActive !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s timeout: dma_active still %b after %0d cycles, want 0", name, dmaActive, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpuIdle();
    repeat (3) @(posedge clock);
    #1;
    compared++;
    if (dmaActive !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_active got %b want 0", dmaActive); end
    compared++;
    if ({mainNread, mainNwrite} !== 2'b11) begin mismatched++; $display("[TB] FAIL reset_strobes got %b want 11", {mainNread, mainNwrite}); end
    compared++;
    if (mainNsel !== 5'b11111) begin mismatched++; $display("[TB] FAIL reset_mainsel got %b want 11111", mainNsel); end
    reset = 1'b0;
    @(negedge clock);
    cpuAddress = 16'hFF46; cpuNread = 1'b0;
    #1;
    compared++;
    if (cpuRdata !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_page got %h want 00", cpuRdata); end
    compared++;
    if ({highNsel, highNread} !== 4'b1111) begin mismatched++; $display("[TB] FAIL reset_dmareg_high got %b want 1111", {highNsel, highNread}); end
    cpuIdle();
  endtask

  task automatic test_passthrough();
    logic [15:0] addrTab [9];
    logic [4:0]  mselTab [9];
    logic [2:0]  hselTab [9];
    addrTab = '{16'h0100, 16'h9000, 16'hA500, 16'hD000, 16'hFE10, 16'hFEA5, 16'hFF10, 16'hFF90, 16'hFFFF};
    mselTab = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11111, 5'b11111, 5'b11111, 5'b11111};
    hselTab = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b101, 3'b011};
    highRdata = 8'h77;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      cpuAddress = addrTab[i]; cpuNread = 1'b0; cpuNwrite = 1'b1;
      #1;
      compared++;
      if (mainNsel !== mselTab[i]) begin mismatched++; $display("[TB] FAIL pass_mainsel @%h got %b want %b", addrTab[i], mainNsel, mselTab[i]); end
      compared++;
      if (highNsel !== hselTab[i]) begin mismatched++; $display("[TB] FAIL pass_highsel @%h got %b want %b", addrTab[i], highNsel, hselTab[i]); end
    end
    @(negedge clock);
    cpuAddress = 16'h0100; cpuNread = 1'b0;
    #1;
    compared++;
    if (cpuRdata !== 8'h3C) begin mismatched++; $display("[TB] FAIL pass_rom_rdata got %h want 3C", cpuRdata); end
    cpuAddress = 16'hFEA5;
    #1;
    compared++;
    if (cpuRdata !== 8'hFF) begin mismatched++; $display("[TB] FAIL pass_unusable_rdata got %h want FF", cpuRdata); end
    cpuAddress = 16'hFF10;
    #1;
    compared++;
    if (cpuRdata !== 8'h77) begin mismatched++; $display("[TB] FAIL pass_high_rdata got %h want 77", cpuRdata); end
    cpuAddress = 16'hFF85; cpuWdata = 8'h5E; cpuNread = 1'b1; cpuNwrite = 1'b0;
    #1;
    compared++;
    if (highNsel !== 3'b101) begin mismatched++; $display("[TB] FAIL pass_hram_wr_sel got %b want 101", highNsel); end
    compared++;
    if ({mainNread, mainNwrite, highNwrite, highWdata} !== {3'b110, 8'h5E}) begin
      mismatched++; $display("[TB] FAIL pass_hram_wr_strobes got %b/%b/%b/%h want 1/1/0/5E", mainNread, mainNwrite, highNwrite, highWdata);
    end
    cpuIdle();
  endtask

  task automatic test_dma_default();
    int t, rb, wb, ab;
    logic [7:0] expData;
    rb = rdAddrQ.size(); wb = wrAddrQ.size(); ab = activeCnt;
    cpuWrite(16'hFF46, 8'hC1);
    t = cyc;
    compared++;
    if (dmaActive !== 1'b1) begin mismatched++; $display("[TB] FAIL dflt_active_t1 got %b want 1", dmaActive); end
    waitDmaDone("dflt");
    #1;
    compared++;
    if (rdAddrQ.size() - rb !== 160) begin mismatched++; $display("[TB] FAIL dflt_read_count got %0d want 160", rdAddrQ.size() - rb); end
    compared++;
    if (wrAddrQ.size() - wb !== 160) begin mismatched++; $display("[TB] FAIL dflt_write_count got %0d want 160", wrAddrQ.size() - wb); end
    compared++;
    if (activeCnt - ab !== 641) begin mismatched++; $display("[TB] FAIL dflt_active_cycles got %0d want 641", activeCnt - ab); end
    for (int k = 0; k < 160; k++) begin
      expData = 8'(k * 7 + 3);
      if (rb + k < rdAddrQ.size()) begin
        compared++;
        if (rdAddrQ[rb + k] !== 16'(16'hC100 + k) || rdCycQ[rb + k] !== t + 2 + 4 * k) begin
          mismatched++; $display("[TB] FAIL dflt_rd[%0d] got %h@%0d want %h@%0d", k, rdAddrQ[rb + k], rdCycQ[rb + k], 16'(16'hC100 + k), t + 2 + 4 * k);
        end
      end
      if (wb + k < wrAddrQ.size()) begin
        compared++;
        if (wrAddrQ[wb + k] !== 16'(16'hFE00 + k) || wrCycQ[wb + k] !== t + 3 + 4 * k || wrDataQ[wb + k] !== expData) begin
          mismatched++; $display("[TB] FAIL dflt_wr[%0d] got %h=%h@%0d want %h=%h@%0d", k, wrAddrQ[wb + k], wrDataQ[wb + k], wrCycQ[wb + k], 16'(16'hFE00 + k), expData, t + 3 + 4 * k);
        end
      end
    end
    @(negedge clock);
    cpuAddress = 16'hFF46; cpuNread = 1'b0;
    #1;
    compared++;
    if (cpuRdata !== 8'hC1) begin mismatched++; $display("[TB] FAIL dflt_page_readback got %h want C1", cpuRdata); end
    cpuIdle();
  endtask

  task automatic test_lockout();
    int wb, stray;
    wb = wrAddrQ.size();
    cpuWrite(16'hFF46, 8'hC1);
    repeat (20) @(negedge clock);
    @(negedge clock);
    cpuAddress = 16'hC000; cpuNread = 1'b0;
    #1;
    compared++;
    if (cpuRdata !== 8'hFF) begin mismatched++; $display("[TB] FAIL lock_main_read got %h want FF", cpuRdata); end
    highRdata = 8'hA5;
    cpuAddress = 16'hFF90;
    #1;
    compared++;
    if (cpuRdata !== 8'hA5 || highNsel !== 3'b101) begin mismatched++; $display("[TB] FAIL lock_high_read got %h/%b want A5/101", cpuRdata, highNsel); end
    cpuAddress = 16'hFF46;
    #1;
    compared++;
    if (cpuRdata !== 8'hC1) begin mismatched++; $display("[TB] FAIL lock_page_read got %h want C1", cpuRdata); end
    cpuAddress = 16'h8000; cpuWdata = 8'h55; cpuNread = 1'b1; cpuNwrite = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    cpuIdle();
    waitDmaDone("lock");
    #1;
    stray = 0;
    for (int i = wb; i < wrAddrQ.size(); i++)
      if (wrAddrQ[i] < 16'hFE00 || wrAddrQ[i] > 16'hFE9F) stray++;
    compared++;
    if (stray !== 0) begin mismatched++; $display("[TB] FAIL lock_cpu_write_leak got %0d stray writes want 0", stray); end
    compared++;
    if (wrAddrQ.size() - wb !== 160) begin mismatched++; $display("[TB] FAIL lock_write_count got %0d want 160", wrAddrQ.size() - wb); end
  endtask

  task automatic test_mirror_restart();
    int t, t2, rb, wb, ab;
    logic [7:0] expData;
    rb = rdAddrQ.size(); wb = wrAddrQ.size(); ab = activeCnt;
    cpuWrite(16'hFF46, 8'hE2);
    t = cyc;
    repeat (40) @(negedge clock);
    cpuWrite(16'hFF46, 8'h80);
    t2 = cyc;
    compared++;
    if (t2 !== t + 41) begin mismatched++; $display("[TB] FAIL mir_restart_edge got %0d want %0d", t2, t + 41); end
    waitDmaDone("mir");
    #1;
    compared++;
    if (wrAddrQ.size() - wb !== 170) begin mismatched++; $display("[TB] FAIL mir_total_writes got %0d want 170", wrAddrQ.size() - wb); end
    compared++;
    if (activeCnt - ab !== 682) begin mismatched++; $display("[TB] FAIL mir_active_cycles got %0d want 682", activeCnt - ab); end
    if (rdAddrQ.size() - rb >= 11) begin
      compared++;
      if (rdAddrQ[rb] !== 16'hC200 || rdAddrQ[rb + 9] !== 16'hC209) begin
        mismatched++; $display("[TB] FAIL mir_echo_src got %h,%h want C200,C209", rdAddrQ[rb], rdAddrQ[rb + 9]);
      end
      compared++;
      if (rdAddrQ[rb + 10] !== 16'h8000 || rdCycQ[rb + 10] !== t2 + 2) begin
        mismatched++; $display("[TB] FAIL mir_restart_rd got %h@%0d want 8000@%0d", rdAddrQ[rb + 10], rdCycQ[rb + 10], t2 + 2);
      end
    end else begin
      compared++; mismatched++;
      $display("[TB] FAIL mir_read_count got %0d want >=11", rdAddrQ.size() - rb);
    end
    for (int k = 0; k < 170; k++) begin
      if (wb + k < wrAddrQ.size()) begin
        expData = (k < 10) ? (8'(k) ^ 8'hA5) : (8'hFF - 8'(k - 10));
        compared++;
        if (wrAddrQ[wb + k] !== 16'(16'hFE00 + ((k < 10) ? k : k - 10)) || wrDataQ[wb + k] !== expData) begin
          mismatched++; $display("[TB] FAIL mir_wr[%0d] got %h=%h want %h=%h", k, wrAddrQ[wb + k], wrDataQ[wb + k], 16'(16'hFE00 + ((k < 10) ? k : k - 10)), expData);
        end
      end
    end
    @(negedge clock);
    cpuAddress = 16'hFF46; cpuNread = 1'b0;
    #1;
    compared++;
    if (cpuRdata !== 8'h80) begin mismatched++; $display("[TB] FAIL mir_page_readback got %h want 80", cpuRdata); end
    cpuIdle();
  endtask

  task automatic test_reset_mid();
    int rb, wb, ab;
    rb = rdAddrQ.size(); wb = wrAddrQ.size(); ab = activeCnt;
    cpuWrite(16'hFF46, 8'hC1);
    repeat (202) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    compared++;
    if ({dmaActive, mainNread, mainNwrite} !== 3'b011) begin
      mismatched++; $display("[TB] FAIL rstmid_idle got act=%b nrd=%b nwr=%b want 0/1/1", dmaActive, mainNread, mainNwrite);
    end
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    compared++;
    if (wrAddrQ.size() - wb !== 50 || rdAddrQ.size() - rb !== 51) begin
      mismatched++; $display("[TB] FAIL rstmid_counts got wr=%0d rd=%0d want 50/51", wrAddrQ.size() - wb, rdAddrQ.size() - rb);
    end
    compared++;
    if (activeCnt - ab !== 202) begin mismatched++; $display("[TB] FAIL rstmid_active_cycles got %0d want 202", activeCnt - ab); end
    if (wb + 49 < wrAddrQ.size()) begin
      compared++;
      if (wrAddrQ[wb + 49] !== 16'hFE31 || wrDataQ[wb + 49] !== 8'(49 * 7 + 3)) begin
        mismatched++; $display("[TB] FAIL rstmid_last_byte got %h=%h want FE31=%h", wrAddrQ[wb + 49], wrDataQ[wb + 49], 8'(49 * 7 + 3));
      end
    end
    @(negedge clock);
    cpuAddress = 16'hFF46; cpuNread = 1'b0;
    #1;
    compared++;
    if (cpuRdata !== 8'h00) begin mismatched++; $display("[TB] FAIL rstmid_page got %h want 00", cpuRdata); end
    cpuIdle();
  endtask

  task automatic test_param_sweep();
    @(negedge clock);
    compared++;
    if (dmaActiveB !== 1'b0) begin mismatched++; $display("[TB] FAIL sweep_pre_active got %b want 0", dmaActiveB); end
    cpuAddressB = 16'hFF46; cpuWdataB = 8'h10; cpuNwriteB = 1'b0;
    @(posedge clock);
    #1;
    cpuNwriteB = 1'b1; cpuAddressB = 16'h0000;
    compared++;
    if ({dmaActiveB, mainNreadB, mainNwriteB, mainAddressB, mainNselB} !== {3'b101, 16'h1000, 5'b11110}) begin
      mismatched++; $display("[TB] FAIL sweep_rd got act=%b nrd=%b nwr=%b a=%h sel=%b want 1/0/1/1000/11110", dmaActiveB, mainNreadB, mainNwriteB, mainAddressB, mainNselB);
    end
    @(posedge clock);
    #1;
    compared++;
    if ({dmaActiveB, mainNreadB, mainNwriteB, mainAddressB, mainWdataB, mainNselB} !== {3'b110, 16'hFE00, 8'h9D, 5'b01111}) begin
      mismatched++; $display("[TB] FAIL sweep_wr got act=%b nrd=%b nwr=%b a=%h d=%h sel=%b want 1/1/0/FE00/9D/01111", dmaActiveB, mainNreadB, mainNwriteB, mainAddressB, mainWdataB, mainNselB);
    end
    @(posedge clock);
    #1;
    compared++;
    if ({dmaActiveB, mainNreadB, mainNwriteB} !== 3'b011) begin
      mismatched++; $display("[TB] FAIL sweep_done got act=%b nrd=%b nwr=%b want 0/1/1", dmaActiveB, mainNreadB, mainNwriteB);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) srcMem[i] = 8'h00;
    srcMem[16'h0100] = 8'h3C;
    for (int k = 0; k < 256; k++) begin
      srcMem[16'hC100 + k] = 8'(k * 7 + 3);
      srcMem[16'hC200 + k] = 8'(k) ^ 8'hA5;
      srcMem[16'h8000 + k] = 8'hFF - 8'(k);
    end
    highRdata = 8'h00;
    cpuAddressB = 16'h0000; cpuWdataB = 8'h00; cpuNreadB = 1'b1; cpuNwriteB = 1'b1;
    $display("[TB] starting gb_dma_interconnect bench");
    test_reset();
    test_passthrough();
    test_dma_default();
    test_lockout();
    test_mirror_restart();
    test_reset_mid();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
